// File: rtl/uart_tx_queue_pkg.sv
// ============================================================================
// Module   : uart_tx_queue_pkg
// Purpose  : Shared types and constants for the keyboard-to-UART byte queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_queue_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } UartTxState_t;

    localparam int UART_TX_QUEUE_DEPTH = 16;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
// ============================================================================
// Module   : uart_byte_fifo
// Purpose  : Circular byte FIFO with registered count/full/empty and a
//            saturating overflow drop counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_next;
    logic                  do_push;
    logic                  do_pop;

    // full is the registered value, so a same-cycle pop never admits a push
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            drop_count <= 8'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == FULL_COUNT);
            empty <= (count_next == '0);
            if (push && full && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_queue.sv
// ============================================================================
// Module   : uart_tx_queue
// Purpose  : Buffers keyboard bytes and hands them one at a time to the UART
//            transmitter while it is idle. Option macro: TX_QUEUE_CRLF_EN
//            (append LF after every transmitted CR).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH        = UART_TX_QUEUE_DEPTH,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      pushData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 dropCount,
    input  logic                       uartBusy,
    output logic                       uartStart,
    output logic [DATA_WIDTH-1:0]      uartData
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    UartTxState_t          state;
    UartTxState_t          state_next;
    logic [TW-1:0]         timer;
    logic                  timeout;
    logic                  pop;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] head;
    logic                  pending_lf;

    uart_byte_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (pushData),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .drop_count (dropCount)
    );

    assign timeout = (timer == TW'(BUSY_TIMEOUT - 1));

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        load_data  = head;
        uartStart  = 1'b0;
        case (state)
            IDLE: begin
                if (pending_lf || !empty) begin
                    load       = 1'b1;
                    state_next = START;
                    if (pending_lf) begin
                        load_data = DATA_WIDTH'(ASCII_LF);
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            START: begin
                uartStart  = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // the timeout covers a busy pulse that was never observed
                if (uartBusy || timeout) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!uartBusy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            uartData <= '0;
        end else begin
            state <= state_next;
            if (state != WAIT_BUSY) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            if (load) begin
                uartData <= load_data;
            end
        end
    end

`ifdef TX_QUEUE_CRLF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_lf <= 1'b0;
        end else if (state == WAIT_BUSY && state_next == WAIT_DONE &&
                     uartData == DATA_WIDTH'(ASCII_CR)) begin
            pending_lf <= 1'b1;
        end else if (load && pending_lf) begin
            pending_lf <= 1'b0;
        end
    end
`else
    assign pending_lf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
// ============================================================================
// Module   : tb_uart_tx_queue
// Purpose  : Directed scoreboard bench for uart_tx_queue with a TxD_busy model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_queue;

    logic       clk;
    logic       rst;
    logic       push;
    logic [7:0] pushData;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic [7:0] dropCount;
    logic       uartBusy;
    logic       uartStart;
    logic [7:0] uartData;

    int         n_asserts = 0;
    int         n_fail    = 0;
    int         cyc       = 0;
    int         busy_mode = 0;   // 0: model, 1: stuck low, 2: stuck high
    int         busy_cnt  = 0;
    bit         prev_start = 1'b0;
    logic [7:0] expq[$];
    int         start_times[$];

    uart_tx_queue dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pushData  (pushData),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .dropCount (dropCount),
        .uartBusy  (uartBusy),
        .uartStart (uartStart),
        .uartData  (uartData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // busy rises the cycle after a start pulse and stays high for 20 cycles
    always @(posedge clk) begin
        if (uartStart) busy_cnt <= 20;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign uartBusy = (busy_mode == 2) || (busy_mode == 0 && busy_cnt != 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (uartStart) begin
            start_times.push_back(cyc);
            chk("start_single_cycle", 32'(prev_start), 32'd0);
            chk("scoreboard_has_entry", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
                chk("tx_byte_order", 32'(uartData), 32'(expq.pop_front()));
            end
        end
        prev_start = uartStart;
    end

    task automatic push_bytes(input logic [7:0] first, input int n, input bit accept);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            push     = 1'b1;
            pushData = first + 8'(i);
            if (accept) expq.push_back(first + 8'(i));
        end
    endtask

    task automatic push_end();
        @(posedge clk); #1;
        push = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n = 0;
        while (start_times.size() < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("start_count", 32'(start_times.size()), 32'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int gap;
        rst      = 1'b1;
        push     = 1'b0;
        pushData = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_drop", 32'(dropCount), 32'd0);
        chk("rst_start", 32'(uartStart), 32'd0);
        chk("rst_data", 32'(uartData), 32'd0);

        // single byte latency
        push_bytes(8'h41, 1, 1'b1);
        push_end();
        @(negedge clk);
        chk("lat_start_early", 32'(uartStart), 32'd0);
        @(negedge clk);
        chk("lat_start", 32'(uartStart), 32'd1);
        chk("lat_data", 32'(uartData), 32'h41);
        chk("lat_empty", 32'(empty), 32'd1);

        // fill to 16 during the busy window, then overflow by 3
        push_bytes(8'h61, 16, 1'b1);
        push_bytes(8'hA0, 3, 1'b0);
        push_end();
        @(negedge clk);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_full", 32'(full), 32'd1);
        chk("ovf_drop3", 32'(dropCount), 32'd3);

        wait_starts(17, 700);
        for (int i = 1; i < 17 && i < start_times.size(); i++) begin
            gap = start_times[i] - start_times[i-1];
            chk("busy_window_gap", 32'(gap >= 22 && gap <= 24), 32'd1);
        end
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_sb", 32'(expq.size()), 32'd0);

        // saturating drop counter with the transmitter stuck busy
        busy_mode = 2;
        push_bytes(8'h80, 17, 1'b1);
        push_bytes(8'hC0, 260, 1'b0);
        push_end();
        @(negedge clk);
        chk("sat_drop", 32'(dropCount), 32'd255);
        chk("sat_count", 32'(count), 32'd16);
        chk("sat_full", 32'(full), 32'd1);
        expq.delete();
        do_reset();
        busy_mode = 0;
        @(negedge clk);
        chk("rst2_count", 32'(count), 32'd0);
        chk("rst2_drop", 32'(dropCount), 32'd0);
        chk("rst2_full", 32'(full), 32'd0);

        // reset during WAIT_DONE with 5 bytes queued
        base = start_times.size();
        push_bytes(8'h31, 1, 1'b1);
        push_end();
        wait_starts(base + 1, 10);
        push_bytes(8'h32, 5, 1'b0);
        push_end();
        @(negedge clk);
        chk("mid_count", 32'(count), 32'd5);
        do_reset();
        @(negedge clk);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_start", 32'(uartStart), 32'd0);
        repeat (40) @(posedge clk);
        chk("no_start_after_rst", 32'(start_times.size()), 32'(base + 1));

        // busy never rises: timeout path
        busy_mode = 1;
        base = start_times.size();
        push_bytes(8'h51, 2, 1'b1);
        push_end();
        wait_starts(base + 2, 40);
        if (start_times.size() >= base + 2) begin
            chk("timeout_gap", 32'(start_times[base+1] - start_times[base]), 32'd7);
        end
        repeat (15) @(posedge clk);
        busy_mode = 0;

        // CR handling
        base = start_times.size();
        expq.push_back(8'h0D);
`ifdef TX_QUEUE_CRLF_EN
        expq.push_back(8'h0A);
`endif
        expq.push_back(8'h42);
        push_bytes(8'h0D, 1, 1'b0);
        push_bytes(8'h42, 1, 1'b0);
        push_end();
`ifdef TX_QUEUE_CRLF_EN
        wait_starts(base + 3, 200);
`else
        wait_starts(base + 2, 200);
`endif
        repeat (30) @(posedge clk);
        chk("final_sb_empty", 32'(expq.size()), 32'd0);
        chk("final_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
